fpu_addsub_arbiter: RTL and testbench

//  Shares one combinational IEEE-754 single-precision add/sub datapath between NUM_REQ requesters
//  (CPU core FPU port plus neuron-update engines) in the accelerator.

---
 rtl/fpu_addsub_arbiter_pkg.sv | 86 ++++++++
 rtl/fpu_addsub_arbiter_rr_arbiter.sv | 31 +++
 rtl/fpu_addsub_arbiter.sv | 122 ++++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_addsub_arbiter_pkg.sv
// Shared FP field widths, FSM state encoding and the truncating single-precision
// add/sub datapath used by fpu_addsub_arbiter.
package fpu_addsub_arbiter_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [FP_W-1:0] result;
    logic            exception;
  } fp_res_t;

  // Larger magnitude first, truncating alignment, no rounding. Exact zero is +0.
  function automatic fp_res_t fp_addsub(input logic [FP_W-1:0] a,
                                        input logic [FP_W-1:0] b,
                                        input logic            sub);
    logic             sa, sb, s_big;
    logic [EXP_W-1:0] ea_raw, eb_raw, ea, eb, e_big, e_sm, diff;
    logic [MAN_W:0]   ma, mb, m_big, m_sm, m_al, m_res;
    logic [MAN_W+1:0] sum;
    logic [EXP_W:0]   e_res;
    logic [4:0]       lz;
    fp_res_t          r;

    r      = '0;
    lz     = 5'd24;
    m_res  = '0;
    e_res  = '0;
    sa     = a[FP_W-1];
    sb     = b[FP_W-1] ^ sub;
    ea_raw = a[FP_W-2:MAN_W];
    eb_raw = b[FP_W-2:MAN_W];
    ma     = {|ea_raw, a[MAN_W-1:0]};
    mb     = {|eb_raw, b[MAN_W-1:0]};
    // Denormals sit at the same scale as exponent 1.
    ea     = (ea_raw == '0) ? 8'd1 : ea_raw;
    eb     = (eb_raw == '0) ? 8'd1 : eb_raw;

    if (a[FP_W-2:0] >= b[FP_W-2:0]) begin
      s_big = sa;  e_big = ea;  e_sm = eb;  m_big = ma;  m_sm = mb;
    end else begin
      s_big = sb;  e_big = eb;  e_sm = ea;  m_big = mb;  m_sm = ma;
    end

    diff = e_big - e_sm;
    m_al = (diff > 8'd23) ? '0 : (m_sm >> diff);
    sum  = (sa == sb) ? ({1'b0, m_big} + {1'b0, m_al})
                      : ({1'b0, m_big} - {1'b0, m_al});

    for (int unsigned i = 0; i <= MAN_W; i++) begin
      if (sum[i]) lz = 5'(MAN_W - i);
    end

    if (sum[MAN_W+1]) begin
      m_res = sum[MAN_W+1:1];
      e_res = {1'b0, e_big} + 9'd1;
    end else if (e_big > {3'b000, lz}) begin
      m_res = sum[MAN_W:0] << lz;
      e_res = {1'b0, e_big} - {4'b0000, lz};
    end else begin
      // Underflow into the denormal range: normalise only as far as exponent 1 allows.
      m_res = sum[MAN_W:0] << (e_big - 8'd1);
      e_res = '0;
    end

    if (ea_raw == EXP_INF || eb_raw == EXP_INF) begin
      r.exception = 1'b1;
    end else if (sum == '0) begin
      r.result = '0;
    end else if (e_res >= 9'd255) begin
      r.result = {s_big, EXP_INF, {MAN_W{1'b0}}};
    end else begin
      r.result = {s_big, (m_res[MAN_W] ? e_res[EXP_W-1:0] : {EXP_W{1'b0}}), m_res[MAN_W-1:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_addsub_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, modulo NUM_REQ,
// and returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  logic [ID_W-1:0] sel;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    sel       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[sel]) begin
        any        = 1'b1;
        grant[sel] = 1'b1;
        grant_idx  = sel;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_arbiter.sv
// Round-robin shared IEEE-754 single-precision add/sub unit: registered operands,
// registered result, one response channel tagged with the requester id.
module fpu_addsub_arbiter
  import fpu_addsub_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_sub,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_result,
  output logic                    rsp_exception
);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr, ptr_nxt;
  logic [FP_W-1:0]     op_a, op_b, sel_a, sel_b;
  logic                op_sub, sel_sub;
  logic [ID_W-1:0]     op_id;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any;
  logic                take;
  fp_res_t             dp;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  assign ptr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[i*FP_W +: FP_W];
        sel_b   = req_b[i*FP_W +: FP_W];
        sel_sub = req_sub[i];
      end
    end
  end

  // The datapath sees only the operand registers.
  always_comb begin
    dp = fp_addsub(op_a, op_b, op_sub);
  end

  // Grants are masked while reset is held so req_ready stays low throughout.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    take      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (RESET_N) begin
          req_ready = grant;
          take      = any;
        end
        if (take) state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = S_RESP;
      S_RESP: begin
        if (rsp_ready && RESET_N) begin
          req_ready = grant;
          take      = any;
          state_nxt = any ? S_EXEC : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      op_a          <= '0;
      op_b          <= '0;
      op_sub        <= 1'b0;
      op_id         <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_result    <= '0;
      rsp_exception <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_sub <= sel_sub;
        op_id  <= grant_idx;
        rr_ptr <= ptr_nxt;
      end
      if (state == S_EXEC) begin
        rsp_valid     <= 1'b1;
        rsp_id        <= op_id;
        rsp_result    <= dp.result;
        rsp_exception <= dp.exception;
      end else if (state == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// Directed bench for fpu_addsub_arbiter with a transaction-level reference model
// checked on every falling clock edge.
module tb_fpu_addsub_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 CLK = 1'b0;
  logic                 RESET_N = 1'b0;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]   req_sub;
  logic                 rsp_valid, rsp_ready, rsp_exception;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          rsp_result;

  fpu_addsub_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_sub       (req_sub),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_exception (rsp_exception)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic with plain integers: {exception, result}.
  function automatic logic [32:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    int          ea, eb, e, d;
    logic [63:0] ma, mb, bm, sm, s;
    logic        sa, sb, sr;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, 32'h0};
    ma = 64'(a[22:0]) + ((ea != 0) ? 64'h800000 : 64'h0);
    mb = 64'(b[22:0]) + ((eb != 0) ? 64'h800000 : 64'h0);
    sa = a[31];
    sb = b[31] ^ sub;
    if (ea == 0) ea = 1;
    if (eb == 0) eb = 1;
    if (a[30:0] >= b[30:0]) begin
      e = ea; bm = ma; sm = mb; sr = sa; d = ea - eb;
    end else begin
      e = eb; bm = mb; sm = ma; sr = sb; d = eb - ea;
    end
    sm = (d >= 32) ? 64'h0 : (sm >> d);
    s  = (sa == sb) ? bm + sm : bm - sm;
    if (s == 0) return 33'h0;
    while (s >= 64'h1000000) begin s = s >> 1; e++; end
    while (s < 64'h800000 && e > 1) begin s = s << 1; e--; end
    if (e >= 255) return {1'b0, sr, 8'hFF, 23'h0};
    return {1'b0, sr, (s >= 64'h800000) ? 8'(e) : 8'h00, s[22:0]};
  endfunction

  // Transaction-level model state.
  typedef struct { int id; logic [32:0] r; } txn_t;
  int   m_ptr = 0;
  bit   m_busy = 0, m_hold = 0;
  txn_t m_pend, m_rsp;
  int   cycle = 0;
  int   grant_log[$], grant_cyc[$], rsp_log[$];

  always @(negedge CLK) begin
    int pick;
    logic [NUM_REQ-1:0] exp_ready;
    bit can;
    cycle++;
    if (!RESET_N) begin
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_rsp_exception", rsp_exception, 0);
      m_ptr = 0; m_busy = 0; m_hold = 0;
    end else begin
      check("rsp_valid", rsp_valid, m_hold);
      if (m_hold) begin
        check("rsp_id", rsp_id, m_rsp.id);
        check("rsp_result", rsp_result, m_rsp.r[31:0]);
        check("rsp_exception", rsp_exception, m_rsp.r[32]);
      end
      can  = (!m_busy && !m_hold) || (m_hold && rsp_ready);
      pick = -1;
      exp_ready = '0;
      if (can) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int i;
          i = (m_ptr + k) % NUM_REQ;
          if (pick < 0 && req_valid[i]) pick = i;
        end
      end
      if (pick >= 0) exp_ready[pick] = 1'b1;
      check("req_ready", req_ready, exp_ready);

      if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i] && req_ready[i]) begin
          grant_log.push_back(i);
          grant_cyc.push_back(cycle);
        end
      end

      if (m_hold && rsp_ready) m_hold = 0;
      if (m_busy) begin m_busy = 0; m_hold = 1; m_rsp = m_pend; end
      if (pick >= 0) begin
        m_pend.id = pick;
        m_pend.r  = fp_model(req_a[pick*32 +: 32], req_b[pick*32 +: 32], req_sub[pick]);
        m_busy    = 1;
        m_ptr     = (pick + 1) % NUM_REQ;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_sub[i]        = s;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_grant(input int i);
    bit got = 0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge CLK);
      if (req_ready != 0) got = 1;
    end
    check("grant_seen", got, 1);
    check("grant_onehot", req_ready, 64'(1) << i);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int id, input logic [31:0] res, input logic exc);
    bit got = 0;
    int k = 0;
    while (!got && k < 30) begin
      @(negedge CLK);
      k++;
      if (rsp_valid) got = 1;
    end
    check("rsp_seen", got, 1);
    check("rsp_latency", k, 2);
    check("lit_rsp_id", rsp_id, id);
    check("lit_rsp_result", rsp_result, res);
    check("lit_rsp_exception", rsp_exception, exc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = 1'b0;

    check("model_1p2", fp_model(32'h3F800000, 32'h40000000, 1'b0), 33'h0_40400000);
    check("model_5m3", fp_model(32'h40A00000, 32'h40400000, 1'b1), 33'h0_40000000);
    check("model_xmx", fp_model(32'h3F800000, 32'h3F800000, 1'b1), 33'h0_00000000);
    check("model_inf", fp_model(32'h7F800000, 32'h3F800000, 1'b0), 33'h1_00000000);
    check("model_2p2", fp_model(32'h40000000, 32'h40000000, 1'b0), 33'h0_40800000);

    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;
    tick();
    rsp_ready = 1'b1;

    // Single add, then subtracts on requester 2.
    tick(); set_op(0, 32'h3F800000, 32'h40000000, 1'b0); wait_grant(0); wait_rsp(0, 32'h40400000, 1'b0);
    tick(); set_op(2, 32'h40A00000, 32'h40400000, 1'b1); wait_grant(2); wait_rsp(2, 32'h40000000, 1'b0);
    tick(); set_op(2, 32'h3F800000, 32'h3F800000, 1'b1); wait_grant(2); wait_rsp(2, 32'h00000000, 1'b0);

    // Infinity operand, then a normal op from the same requester.
    tick(); set_op(3, 32'h7F800000, 32'h3F800000, 1'b0); wait_grant(3); wait_rsp(3, 32'h00000000, 1'b1);
    tick(); set_op(3, 32'h3F800000, 32'h40000000, 1'b0); wait_grant(3); wait_rsp(3, 32'h40400000, 1'b0);

    // Fairness with all requesters held valid.
    tick();
    grant_log.delete(); grant_cyc.delete(); rsp_log.delete();
    set_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
    set_op(1, 32'h40000000, 32'h3F800000, 1'b1);
    set_op(2, 32'h40400000, 32'h3F800000, 1'b0);
    set_op(3, 32'h40800000, 32'h3F800000, 1'b1);
    for (int k = 0; k < 40 && grant_log.size() < 5; k++) @(negedge CLK);
    tick();
    req_valid = '0;
    repeat (6) tick();
    check("fair_grant_count", grant_log.size(), 5);
    check("fair_rsp_count", rsp_log.size(), 5);
    for (int j = 0; j < 5 && j < grant_log.size(); j++) begin
      check("fair_grant_order", grant_log[j], j % 4);
      if (j > 0) check("fair_grant_spacing", grant_cyc[j] - grant_cyc[j-1], 2);
    end
    for (int j = 0; j < 5 && j < rsp_log.size(); j++) check("fair_rsp_order", rsp_log[j], j % 4);

    // Backpressure: result held, no grants, release grants pending req1 at once.
    tick();
    rsp_ready = 1'b0;
    set_op(0, 32'h40800000, 32'h3F800000, 1'b0); wait_grant(0); wait_rsp(0, 32'h40A00000, 1'b0);
    tick();
    set_op(1, 32'h3FC00000, 32'h3F000000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_req_ready", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_result", rsp_result, 32'h40A00000);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("bp_release_grant", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, 32'h3F800000, 1'b0);

    // Reset while the op is executing; pointer must return to 0.
    tick();
    set_op(2, 32'h40000000, 32'h40000000, 1'b0); wait_grant(2);
    #2 RESET_N = 1'b0;
    set_op(2, 32'h40000000, 32'h40000000, 1'b0);
    set_op(3, 32'h3F800000, 32'hBF800000, 1'b0);
    #1;
    check("rst_rsp_valid_now", rsp_valid, 0);
    check("rst_req_ready_now", req_ready, 0);
    check("rst_rsp_result_now", rsp_result, 0);
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    wait_grant(2);
    wait_rsp(2, 32'h40800000, 1'b0);
    check("same_cycle_grant3", req_ready, 4'b1000);
    tick();
    req_valid[3] = 1'b0;
    wait_rsp(3, 32'h00000000, 1'b0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
